mod_signal_switcher: RTL

- Registered, parametrised selector for NSIG baseband waveforms and NMOD modulator families, each family with NSIG channels.
- Sits between the waveform/modulator cores and the DAC path. Nios-written selections are applied only on a sample_tick.
- A modulation change is deferred until the current modulated output rises through midscale, or until a timeout expires. This prevents discontinuities in the DAC output.

---
 rtl/mod_signal_switcher.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mod_signal_switcher.sv
// rtl/mod_signal_switcher.sv - glitch-free signal/modulation selector feeding the DAC path
module mod_signal_switcher #(
    parameter int W       = 12,
    parameter int NSIG    = 4,
    parameter int NMOD    = 3,
    parameter int TIMEOUT = 4096,
    parameter int MID     = 2048
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_tick,
    input  logic [NSIG*W-1:0]      sig_in,
    input  logic [NMOD*NSIG*W-1:0] mod_in,
    input  logic [7:0]             sel_sig,
    input  logic [3:0]             sel_mod,
    input  logic                   sel_load,
    output logic                   sel_busy,
    output logic                   sel_err,
    output logic [7:0]             active_sig,
    output logic [3:0]             active_mod,
    output logic [W-1:0]           selected_signal,
    output logic [W-1:0]           selected_modulation,
    output logic                   out_valid
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [W-1:0]   MID_L    = W'(MID);
    localparam logic [7:0]     NSIG_L   = 8'(NSIG);
    localparam logic [3:0]     NMOD_L   = 4'(NMOD);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    act_sig_q, act_sig_d;
    logic [3:0]    act_mod_q, act_mod_d;
    logic [7:0]    pend_sig_q, pend_sig_d;
    logic [3:0]    pend_mod_q, pend_mod_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [W-1:0]  ssig_q, ssig_d;
    logic [W-1:0]  smod_q, smod_d;
    logic          valid_q, valid_d;

    logic [7:0]    eff_sig;
    logic [3:0]    eff_mod;
    logic [W-1:0]  cand;
    logic          crossing;

    // Channel s of a packed signal bus; indices are always in range once loaded.
    function automatic logic [W-1:0] pick_sig(input logic [NSIG*W-1:0] v, input logic [7:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NSIG; i++) begin
            if (s == 8'(i)) r = v[i*W +: W];
        end
        return r;
    endfunction

    // Family m, channel s of the packed modulator bus.
    function automatic logic [W-1:0] pick_mod(input logic [NMOD*NSIG*W-1:0] v,
                                              input logic [3:0] m, input logic [7:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NMOD; i++) begin
            for (int j = 0; j < NSIG; j++) begin
                if (m == 4'(i) && s == 8'(j)) r = v[(i*NSIG+j)*W +: W];
            end
        end
        return r;
    endfunction

    // Next-state: load handling in IDLE, crossing/timeout-gated switch in ARMED, sample datapath.
    always_comb begin
        state_d    = state_q;
        act_sig_d  = act_sig_q;
        act_mod_d  = act_mod_q;
        pend_sig_d = pend_sig_q;
        pend_mod_d = pend_mod_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        prev_d     = prev_q;
        ssig_d     = ssig_q;
        smod_d     = smod_q;
        valid_d    = sample_tick;
        eff_sig    = act_sig_q;
        eff_mod    = act_mod_q;
        cand       = pick_mod(mod_in, act_mod_q, act_sig_q);
        crossing   = (prev_q < MID_L) && (cand >= MID_L);

        case (state_q)
            IDLE: begin
                if (sel_load) begin
                    if (sel_sig < NSIG_L && sel_mod < NMOD_L) begin
                        pend_sig_d = sel_sig;
                        pend_mod_d = sel_mod;
                        err_d      = 1'b0;
                        state_d    = ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (sample_tick) begin
                    if ((pend_sig_q == act_sig_q && pend_mod_q == act_mod_q) ||
                        crossing || cnt_q == CNT_LAST) begin
                        // The switching tick already samples through the new indices.
                        act_sig_d = pend_sig_q;
                        act_mod_d = pend_mod_q;
                        eff_sig   = pend_sig_q;
                        eff_mod   = pend_mod_q;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample_tick) begin
            ssig_d = pick_sig(sig_in, eff_sig);
            smod_d = pick_mod(mod_in, eff_mod, eff_sig);
            prev_d = smod_d;
        end
    end

    // State and datapath registers; reset discards any pending selection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            act_sig_q  <= '0;
            act_mod_q  <= '0;
            pend_sig_q <= '0;
            pend_mod_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            prev_q     <= '0;
            ssig_q     <= '0;
            smod_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_sig_q  <= act_sig_d;
            act_mod_q  <= act_mod_d;
            pend_sig_q <= pend_sig_d;
            pend_mod_q <= pend_mod_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            prev_q     <= prev_d;
            ssig_q     <= ssig_d;
            smod_q     <= smod_d;
            valid_q    <= valid_d;
        end
    end

    assign sel_busy            = (state_q == ARMED);
    assign sel_err             = err_q;
    assign active_sig          = act_sig_q;
    assign active_mod          = act_mod_q;
    assign selected_signal     = ssig_q;
    assign selected_modulation = smod_q;
    assign out_valid           = valid_q;

endmodule
